// File: rtl/sevenseg_scan_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment encoding: bit0=a ... bit6=g, active-high.
package sevenseg_scan_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b1100111;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/sevenseg_scan_bcd_to_seg.sv
// Combinational BCD to seven-segment decode.
// Ports: bcd (4-bit nibble in), seg_c (7-bit segments out, non-BCD codes dark).
module bcd_to_seg
    import sevenseg_scan_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed multi-digit seven-segment driver with frame-aligned
// double buffering, blanking window, leading-zero suppression and decimal points.
// Ports: clk, rstn (async active-low), enable, load/value (BCD nibbles),
//        dp, lz_blank in; segments, seg_dp, digit_en, frame_done, pending out.
module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 50
)(
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    input  logic                lz_blank,
    output logic [SEG_W-1:0]    segments,
    output logic                seg_dp,
    output logic [DIGITS-1:0]   digit_en,
    output logic                frame_done,
    output logic                pending
);

    localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    logic [TW-1:0]     tick_q, tick_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [VW-1:0]     active_q, active_d;
    logic [VW-1:0]     shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [SEG_W-1:0]  segments_q, segments_d;
    logic              seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0] digit_en_q, digit_en_d;
    logic              frame_done_q, frame_done_d;

    logic              tick_last_c, slot_last_c, wrap_c;
    logic [3:0]        nibble_c;
    logic              dp_sel_c, supp_c, any_nz_c;
    logic [DIGITS-1:0] sel_c, lz_zero_c;
    logic [SEG_W-1:0]  seg_c;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_q       <= '0;
            slot_q       <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            segments_q   <= '0;
            seg_dp_q     <= 1'b0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            slot_q       <= slot_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            segments_q   <= segments_d;
            seg_dp_q     <= seg_dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scan counters; the wrap edge is the last tick of the last slot
    always_comb begin
        tick_last_c = (tick_q == TW'(PRESCALE - 1));
        slot_last_c = (slot_q == SW'(DIGITS - 1));
        wrap_c      = enable & tick_last_c & slot_last_c;
        tick_d      = tick_q;
        slot_d      = slot_q;
        if (!enable) begin
            tick_d = '0;
            slot_d = '0;
        end else if (tick_last_c) begin
            tick_d = '0;
            slot_d = slot_last_c ? '0 : slot_q + SW'(1);
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    // Double buffer: new data reaches the display only on a frame boundary
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (!enable) begin
            if (load) begin
                active_d  = value;
                pending_d = 1'b0;
            end
        end else if (wrap_c) begin
            if (load) begin
                active_d  = value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    // lz_zero_c[k]: all active nibbles from the top digit down to k are zero
    always_comb begin
        any_nz_c  = 1'b0;
        lz_zero_c = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            any_nz_c     = any_nz_c | (active_q[4*k +: 4] != 4'd0);
            lz_zero_c[k] = ~any_nz_c;
        end
    end

    // Current-slot selection
    always_comb begin
        nibble_c = 4'd0;
        dp_sel_c = 1'b0;
        supp_c   = 1'b0;
        sel_c    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (slot_q == SW'(k)) begin
                nibble_c = active_q[4*k +: 4];
                dp_sel_c = dp[k];
                sel_c[k] = 1'b1;
                supp_c   = lz_blank && (k != 0) && lz_zero_c[k];
            end
        end
    end

    bcd_to_seg u_dec (
        .bcd   (nibble_c),
        .seg_c (seg_c)
    );

    // Output window: dark during blank ticks; suppressed digits keep only dp
    always_comb begin
        segments_d   = SEG_OFF;
        seg_dp_d     = 1'b0;
        digit_en_d   = '0;
        frame_done_d = wrap_c;
        if (enable && (tick_q >= TW'(BLANK))) begin
            seg_dp_d = dp_sel_c;
            if (!supp_c) begin
                digit_en_d = sel_c;
                segments_d = seg_c;
            end
        end
    end

    assign segments   = segments_q;
    assign seg_dp     = seg_dp_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed self-checking bench for sevenseg_scan (DIGITS=4, PRESCALE=8, BLANK=2).
module tb_sevenseg_scan;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz_blank;
    logic [6:0]  segments;
    logic        seg_dp;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic        pending;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111100;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;

    sevenseg_scan #(
        .DIGITS   (4),
        .PRESCALE (8),
        .BLANK    (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .lz_blank   (lz_blank),
        .segments   (segments),
        .seg_dp     (seg_dp),
        .digit_en   (digit_en),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_out(input string tag, input logic [3:0] den, input logic [6:0] seg,
                             input logic sdp);
        check({tag, ".digit_en"}, 32'(digit_en), 32'(den));
        check({tag, ".segments"}, 32'(segments), 32'(seg));
        check({tag, ".seg_dp"},   32'(seg_dp),   32'(sdp));
    endtask

    // Stop, load directly into the active buffer, then restart scan at slot 0 tick 0
    task automatic restart(input logic [15:0] v);
        enable = 1'b0;
        step();
        load  = 1'b1;
        value = v;
        step();
        load   = 1'b0;
        enable = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        rstn     = 1'b0;
        enable   = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        lz_blank = 1'b0;
        step();
        step();
        check_out("rst", 4'b0000, 7'b0, 1'b0);
        check("rst.pending", 32'(pending), 32'd0);
        check("rst.frame_done", 32'(frame_done), 32'd0);

        // 1: free run, async reset at slot 2 tick 5, restart and frame period
        rstn = 1'b1;
        cyc  = 0;
        run_to(117);
        check_out("t1.pre_rst", 4'b0100, S0, 1'b0);
        rstn = 1'b0;
        #2;
        check_out("t1.async_rst", 4'b0000, 7'b0, 1'b0);
        check("t1.async_rst.frame_done", 32'(frame_done), 32'd0);
        step();
        rstn = 1'b1;
        cyc  = 0;
        run_to(31);
        check("t1.fd31", 32'(frame_done), 32'd0);
        run_to(32);
        check("t1.fd32", 32'(frame_done), 32'd1);
        run_to(33);
        check("t1.fd33", 32'(frame_done), 32'd0);
        run_to(63);
        check("t1.fd63", 32'(frame_done), 32'd0);
        run_to(64);
        check("t1.fd64", 32'(frame_done), 32'd1);

        // 2: load while disabled, then scan 0x1234
        restart(16'h1234);
        check("t2.pending", 32'(pending), 32'd0);
        run_to(1);
        check_out("t2.blank0", 4'b0000, 7'b0, 1'b0);
        run_to(2);
        check_out("t2.blank1", 4'b0000, 7'b0, 1'b0);
        run_to(3);
        check_out("t2.slot0", 4'b0001, S4, 1'b0);
        run_to(11);
        check_out("t2.slot1", 4'b0010, S3, 1'b0);
        run_to(19);
        check_out("t2.slot2", 4'b0100, S2, 1'b0);
        run_to(26);
        check_out("t2.slot3_blank", 4'b0000, 7'b0, 1'b0);
        run_to(27);
        check_out("t2.slot3", 4'b1000, S1, 1'b0);

        // 3: mid-frame load is held until the frame boundary
        run_to(42);
        load  = 1'b1;
        value = 16'h5678;
        step();
        load = 1'b0;
        check("t3.pending_set", 32'(pending), 32'd1);
        run_to(46);
        check_out("t3.slot1_old", 4'b0010, S3, 1'b0);
        run_to(51);
        check_out("t3.slot2_old", 4'b0100, S2, 1'b0);
        run_to(59);
        check_out("t3.slot3_old", 4'b1000, S1, 1'b0);
        run_to(63);
        check("t3.pending_pre_wrap", 32'(pending), 32'd1);
        check("t3.fd_pre_wrap", 32'(frame_done), 32'd0);
        run_to(64);
        check("t3.pending_wrap", 32'(pending), 32'd0);
        check("t3.fd_wrap", 32'(frame_done), 32'd1);
        run_to(67);
        check_out("t3.slot0_new", 4'b0001, S8, 1'b0);

        // 4: repeated loads, last one on the wrap edge wins
        run_to(70);
        load  = 1'b1;
        value = 16'h1111;
        step();
        load = 1'b0;
        run_to(80);
        load  = 1'b1;
        value = 16'h2222;
        step();
        load = 1'b0;
        run_to(95);
        check("t4.pending_pre_wrap", 32'(pending), 32'd1);
        load  = 1'b1;
        value = 16'h9876;
        step();
        load = 1'b0;
        check("t4.pending_wrap", 32'(pending), 32'd0);
        check("t4.fd_wrap", 32'(frame_done), 32'd1);
        run_to(99);
        check_out("t4.slot0", 4'b0001, S6, 1'b0);
        run_to(107);
        check_out("t4.slot1", 4'b0010, S7, 1'b0);
        run_to(128);
        check("t4.pending_next", 32'(pending), 32'd0);
        check("t4.fd_next", 32'(frame_done), 32'd1);
        run_to(131);
        check_out("t4.slot0_kept", 4'b0001, S6, 1'b0);

        // 5: leading-zero suppression
        lz_blank = 1'b1;
        restart(16'h0050);
        run_to(3);
        check_out("t5a.slot0", 4'b0001, S0, 1'b0);
        run_to(11);
        check_out("t5a.slot1", 4'b0010, S5, 1'b0);
        run_to(19);
        check_out("t5a.slot2", 4'b0000, 7'b0, 1'b0);
        run_to(27);
        check_out("t5a.slot3", 4'b0000, 7'b0, 1'b0);
        dp = 4'b0010;
        restart(16'h0000);
        run_to(3);
        check_out("t5b.slot0", 4'b0001, S0, 1'b0);
        run_to(11);
        check_out("t5b.slot1_dp", 4'b0000, 7'b0, 1'b1);
        run_to(27);
        check_out("t5b.slot3", 4'b0000, 7'b0, 1'b0);

        // 6: non-BCD nibble with decimal point, then disable mid-slot
        lz_blank = 1'b0;
        dp       = 4'b0100;
        restart(16'h0A00);
        run_to(19);
        check_out("t6.slot2_nonbcd", 4'b0100, 7'b0, 1'b1);
        run_to(21);
        check_out("t6.slot2_mid", 4'b0100, 7'b0, 1'b1);
        enable = 1'b0;
        step();
        check_out("t6.disabled", 4'b0000, 7'b0, 1'b0);
        check("t6.disabled.frame_done", 32'(frame_done), 32'd0);
        check("t6.disabled.pending", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
